// File: rtl/text_page_loader.sv
// text_page_loader
// Copies the page selected by the menu renderer from the page ROM into the
// character RAM, only during vertical blanking, so the renderer never reads a
// half-written page. A load that is cut short by the end of vblank leaves the
// RAM marked stale and is redone from index 0 on the next vblank edge.
//
// Handshake: there is no valid/ready pair here. A write to the character RAM
// happens on exactly the cycles where cram_we is high. The ROM is read with a
// fixed one-cycle latency, so each ROM address issued is paired with a write
// one cycle later. load_done is a one-cycle pulse that marks a complete page.
module text_page_loader #(
  parameter int N_CHARS = 256,
  parameter int DATA_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic [1:0]        select_text,
  input  logic              force_reload,
  output logic [9:0]        rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              cram_we,
  output logic [7:0]        cram_addr,
  output logic [DATA_W-1:0] cram_wdata,
  output logic              busy,
  output logic              load_done,
  output logic [1:0]        loaded_page,
  output logic              page_valid,
  output logic              state_dbg
);

  // idx must be able to hold N_CHARS itself, which marks "all reads issued"
  localparam int IDX_W = 9;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_CHARS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               vblnk_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         target_q;
  logic               wr_valid_q;
  logic [7:0]         wr_idx_q;
  logic [1:0]         loaded_page_q;
  logic               loaded_ok_q;
  logic               force_seen_q;
  logic               load_done_q;
  logic               page_valid_q;

  logic vblank_edge;
  logic pending;
  logic start;
  logic issue;
  logic finish;
  logic busy_next;

  // Qualifiers shared by the FSM and the datapath
  always_comb begin
    vblank_edge = vblnk & ~vblnk_q;
    pending     = ~loaded_ok_q | (select_text != loaded_page_q) | force_seen_q;
    start       = (state_q == S_IDLE) & vblank_edge & pending;
    // A ROM read is issued while indices remain and vblank is still active
    issue       = (state_q == S_LOAD) & (idx_q < IDX_END) & vblnk;
    // Last write has just gone out and vblank held to the end
    finish      = (state_q == S_LOAD) & vblnk & (idx_q == IDX_END);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave LOAD on completion or as soon as vblank drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (!vblnk || (idx_q == IDX_END)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs and ROM/RAM port drive
  always_comb begin
    busy       = (state_q == S_LOAD);
    busy_next  = (state_d == S_LOAD);
    state_dbg  = state_q;
    rom_addr   = {target_q, idx_q[7:0]};
    cram_we    = wr_valid_q;
    cram_addr  = wr_idx_q;
    cram_wdata = wr_valid_q ? rom_data : '0;
    load_done   = load_done_q;
    loaded_page = loaded_page_q;
    page_valid  = page_valid_q;
  end

  // Read index: advances once per issued read, parked at 0 outside LOAD
  always_comb begin
    idx_d = idx_q;
    if (state_d != S_LOAD) begin
      idx_d = '0;
    end else if (issue) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Datapath and page bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q       <= 1'b0;
      idx_q         <= '0;
      target_q      <= 2'd0;
      wr_valid_q    <= 1'b0;
      wr_idx_q      <= 8'd0;
      loaded_page_q <= 2'd0;
      loaded_ok_q   <= 1'b0;
      force_seen_q  <= 1'b0;
      load_done_q   <= 1'b0;
      page_valid_q  <= 1'b0;
    end else begin
      vblnk_q    <= vblnk;
      idx_q      <= idx_d;
      // The write lags its ROM read by one cycle; an abort drops the read in flight
      wr_valid_q <= issue;
      if (issue) begin
        wr_idx_q <= idx_q[7:0];
      end
      if (start) begin
        target_q    <= select_text;
        loaded_ok_q <= 1'b0;
      end else if (finish) begin
        loaded_ok_q   <= 1'b1;
        loaded_page_q <= target_q;
      end
      // A request arriving on the start cycle itself is kept for the next vblank
      if (force_reload) begin
        force_seen_q <= 1'b1;
      end else if (start) begin
        force_seen_q <= 1'b0;
      end
      load_done_q  <= finish;
      page_valid_q <= loaded_ok_q & (select_text == loaded_page_q) & ~busy_next;
    end
  end

endmodule

// File: tb/tb_text_page_loader.sv
// Bench for text_page_loader: directed frame scenarios, a synchronous ROM
// model, a per-cycle reference model expressed as offsets from the vblank edge
// that started a load, and literal end-of-scenario expectations.
module tb_text_page_loader;

  localparam int N  = 256;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          vblnk;
  logic [1:0]    select_text;
  logic          force_reload;
  logic [9:0]    rom_addr;
  logic [DW-1:0] rom_data;
  logic          cram_we;
  logic [7:0]    cram_addr;
  logic [DW-1:0] cram_wdata;
  logic          busy;
  logic          load_done;
  logic [1:0]    loaded_page;
  logic          page_valid;
  logic          state_dbg;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  text_page_loader #(.N_CHARS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .select_text(select_text),
    .force_reload(force_reload), .rom_addr(rom_addr), .rom_data(rom_data),
    .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
    .busy(busy), .load_done(load_done), .loaded_page(loaded_page),
    .page_valid(page_valid), .state_dbg(state_dbg)
  );

  // Page ROM contents: an arbitrary, address-dependent pattern
  function automatic logic [DW-1:0] rom_f(input logic [9:0] a);
    int v;
    v = int'(a);
    return DW'((v * 37 + (v >> 3) + 5) % 128);
  endfunction

  // Synchronous ROM with one cycle of latency
  always @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A load started by the vblank edge seen in cycle E is described only by E
  // and the latched page; every output follows from k = cycle - E.
  int         cyc     = 0;
  logic       m_load  = 1'b0;
  int         m_start = 0;
  logic [1:0] m_tgt   = 2'd0;
  logic       m_ok    = 1'b0;
  logic [1:0] m_page  = 2'd0;
  logic       m_force = 1'b0;
  logic       m_pv    = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_vbp   = 1'b0;
  logic       ok_pre;
  logic [1:0] pg_pre;
  logic       m_go;
  int         k_p;

  always @(posedge clk) begin
    ok_pre = m_ok;
    pg_pre = m_page;
    m_done = 1'b0;
    if (rst) begin
      m_load = 1'b0; m_tgt = 2'd0; m_ok = 1'b0; m_page = 2'd0;
      m_force = 1'b0; m_pv = 1'b0; m_vbp = 1'b0;
    end else begin
      m_go = vblnk && !m_vbp && !m_load &&
             (!m_ok || (select_text != m_page) || m_force);
      if (m_load) begin
        k_p = cyc - m_start;
        if (!vblnk) begin
          m_load = 1'b0;
        end else if (k_p == N + 1) begin
          m_load = 1'b0; m_done = 1'b1; m_ok = 1'b1; m_page = m_tgt;
        end
      end
      if (m_go) begin
        m_load = 1'b1; m_start = cyc; m_tgt = select_text;
        m_ok = 1'b0; m_force = 1'b0;
      end
      if (force_reload) m_force = 1'b1;
      m_pv  = ok_pre && (select_text == pg_pre) && !m_load;
      m_vbp = vblnk;
    end
    cyc++;
  end

  // ---------------- scoreboard / observers ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] shadow[N];
  int   wr_cnt    = 0;
  int   busy_cnt  = 0;
  int   done_cnt  = 0;
  int   first_adr = -1;
  int   min_ra    = 1024;
  int   max_ra    = -1;
  int   k_n;
  logic [9:0] ea;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      k_n = cyc - m_start;
      chk("busy", 32'(busy), 32'(m_load));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("loaded_page", 32'(loaded_page), 32'(m_page));
      chk("page_valid", 32'(page_valid), 32'(m_pv));
      chk("cram_we", 32'(cram_we), 32'(m_load && k_n >= 2));
      if (m_load && k_n >= 1 && k_n <= N) begin
        ea = {m_tgt, 8'(k_n - 1)};
        chk("rom_addr", 32'(rom_addr), 32'(ea));
      end
      if (m_load && k_n >= 2) begin
        ea = {m_tgt, 8'(k_n - 2)};
        exp_q.push_back(rom_f(ea));
        chk("cram_addr", 32'(cram_addr), 32'(k_n - 2));
        chk("cram_wdata", 32'(cram_wdata), 32'(exp_q.pop_front()));
      end
    end
    if (cram_we === 1'b1) begin
      if (wr_cnt == 0) first_adr = int'(cram_addr);
      wr_cnt++;
      shadow[cram_addr] = cram_wdata;
    end
    if (busy === 1'b1) begin
      busy_cnt++;
      if (int'(rom_addr) < min_ra) min_ra = int'(rom_addr);
      if (int'(rom_addr) > max_ra) max_ra = int'(rom_addr);
    end
    if (load_done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    wr_cnt = 0; busy_cnt = 0; first_adr = -1; min_ra = 1024; max_ra = -1;
  endtask

  task automatic pulse_force();
    force_reload = 1'b1;
    tick(1);
    force_reload = 1'b0;
  endtask

  task automatic check_shadow(input string name, input logic [1:0] pg);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (shadow[i] !== rom_f({pg, 8'(i)})) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; vblnk = 1'b0; select_text = 2'd0; force_reload = 1'b0;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_cram_we", 32'(cram_we), 32'd0);
    chk("rst_page_valid", 32'(page_valid), 32'd0);
    rst = 1'b0;
    tick(5);

    // Reset load of page 0
    clear_obs(); done_cnt = 0;
    vblnk = 1'b1;
    tick(N + 10);
    chk("p0_writes", 32'(wr_cnt), 32'd256);
    chk("p0_first", 32'(first_adr), 32'd0);
    chk("p0_done_cnt", 32'(done_cnt), 32'd1);
    chk("p0_loaded", 32'(loaded_page), 32'd0);
    chk("p0_valid", 32'(page_valid), 32'd1);
    check_shadow("p0_ram", 2'd0);
    vblnk = 1'b0;
    tick(20);

    // Idle frame: nothing stale, nothing written
    clear_obs();
    vblnk = 1'b1;
    tick(300);
    chk("idle_writes", 32'(wr_cnt), 32'd0);
    chk("idle_busy", 32'(busy_cnt), 32'd0);
    vblnk = 1'b0;
    tick(10);

    // Page switch 0 -> 2
    select_text = 2'd2;
    tick(1);
    chk("sw_valid_drop", 32'(page_valid), 32'd0);
    tick(5);
    clear_obs();
    vblnk = 1'b1;
    tick(270);
    chk("p2_min_addr", 32'(min_ra), 32'd512);
    chk("p2_max_addr", 32'(max_ra), 32'd767);
    chk("p2_writes", 32'(wr_cnt), 32'd256);
    chk("p2_loaded", 32'(loaded_page), 32'd2);
    chk("p2_valid", 32'(page_valid), 32'd1);
    check_shadow("p2_ram", 2'd2);
    vblnk = 1'b0;
    tick(10);

    // Abort after 100 writes, then full reload of page 1
    select_text = 2'd1;
    tick(2);
    clear_obs(); done_cnt = 0;
    vblnk = 1'b1;
    tick(101);
    vblnk = 1'b0;
    tick(10);
    chk("ab_writes", 32'(wr_cnt), 32'd100);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done_cnt), 32'd0);
    chk("ab_valid", 32'(page_valid), 32'd0);
    chk("ab_loaded", 32'(loaded_page), 32'd2);
    clear_obs();
    vblnk = 1'b1;
    tick(270);
    chk("rl_writes", 32'(wr_cnt), 32'd256);
    chk("rl_first", 32'(first_adr), 32'd0);
    chk("rl_loaded", 32'(loaded_page), 32'd1);
    chk("rl_valid", 32'(page_valid), 32'd1);
    check_shadow("p1_ram", 2'd1);
    vblnk = 1'b0;
    tick(10);

    // Select change 1 -> 3 during a forced reload of page 1
    pulse_force();
    tick(2);
    clear_obs();
    vblnk = 1'b1;
    tick(50);
    select_text = 2'd3;
    tick(230);
    chk("mid_writes", 32'(wr_cnt), 32'd256);
    chk("mid_loaded", 32'(loaded_page), 32'd1);
    chk("mid_valid", 32'(page_valid), 32'd0);
    check_shadow("mid_ram", 2'd1);
    vblnk = 1'b0;
    tick(10);
    clear_obs();
    vblnk = 1'b1;
    tick(270);
    chk("p3_loaded", 32'(loaded_page), 32'd3);
    chk("p3_valid", 32'(page_valid), 32'd1);
    check_shadow("p3_ram", 2'd3);
    vblnk = 1'b0;
    tick(10);

    // force_reload while busy gives exactly one extra reload
    select_text = 2'd0;
    tick(2);
    vblnk = 1'b1;
    tick(20);
    pulse_force();
    tick(260);
    chk("fb_loaded", 32'(loaded_page), 32'd0);
    chk("fb_valid", 32'(page_valid), 32'd1);
    vblnk = 1'b0;
    tick(10);
    clear_obs();
    vblnk = 1'b1;
    tick(270);
    chk("fb_extra_writes", 32'(wr_cnt), 32'd256);
    vblnk = 1'b0;
    tick(10);
    clear_obs();
    vblnk = 1'b1;
    tick(270);
    chk("fb_no_more", 32'(wr_cnt), 32'd0);
    vblnk = 1'b0;
    tick(10);

    // Reset in the middle of a load of page 2
    select_text = 2'd2;
    tick(2);
    clear_obs();
    vblnk = 1'b1;
    tick(51);
    rst = 1'b1;
    tick(1);
    chk("rm_writes", 32'(wr_cnt), 32'd50);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_we", 32'(cram_we), 32'd0);
    chk("rm_cram_addr", 32'(cram_addr), 32'd0);
    chk("rm_cram_wdata", 32'(cram_wdata), 32'd0);
    chk("rm_rom_addr", 32'(rom_addr), 32'd0);
    chk("rm_loaded", 32'(loaded_page), 32'd0);
    chk("rm_valid", 32'(page_valid), 32'd0);
    chk("rm_done", 32'(load_done), 32'd0);
    tick(2);
    chk("rm_no_writes", 32'(wr_cnt), 32'd50);
    vblnk = 1'b0;
    rst = 1'b0;
    tick(5);
    clear_obs();
    vblnk = 1'b1;
    tick(270);
    chk("rr_writes", 32'(wr_cnt), 32'd256);
    chk("rr_first", 32'(first_adr), 32'd0);
    chk("rr_loaded", 32'(loaded_page), 32'd2);
    chk("rr_valid", 32'(page_valid), 32'd1);
    check_shadow("rr_ram", 2'd2);
    vblnk = 1'b0;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_page_loader.md
# text_page_loader

Controller that fills the character-code RAM read by the menu text renderer with the page selected by the menu state machine. It watches the current page selection (`select_text`) and the VGA `vblnk` signal. When the displayed page is stale, it copies the selected page from the page ROM into the character RAM during vertical blanking only, so the renderer never reads a half-written page mid-frame. It sits between the menu text renderer, the page ROM and the write port of the character RAM.

## Interface
Parameters:
- `N_CHARS`, default 256: characters per page; also the character RAM depth. `char_xy` is 8 bits, so the maximum is 256.
- `DATA_W`, default 7: width of a character code.

Ports:
- `clk`, input, 1: pixel clock.
- `rst`, input, 1: synchronous, active-high reset.
- `vblnk`, input, 1: vertical blank from the VGA timing chain.
- `select_text`, input, 2: page requested by the menu renderer.
- `force_reload`, input, 1: single-cycle pulse; forces a reload at the next vblank.
- `rom_addr`, output, 10: page ROM address = {page[1:0], idx[7:0]}.
- `rom_data`, input, DATA_W: page ROM read data; synchronous ROM, 1-cycle latency.
- `cram_we`, output, 1: character RAM write enable.
- `cram_addr`, output, 8: character RAM write address.
- `cram_wdata`, output, DATA_W: character RAM write data.
- `busy`, output, 1: high while a load is in progress.
- `load_done`, output, 1: single-cycle pulse when a load completes.
- `loaded_page`, output, 2: page currently held in the character RAM.
- `page_valid`, output, 1: RAM holds a complete copy of `select_text`.

## Operation
- States: IDLE, LOAD.
- `vblnk` is registered into `vblnk_q`. A vblank edge occurs on a cycle where `vblnk`=1 and `vblnk_q`=0.
- `pending` = !`loaded_ok` || (`select_text` != `loaded_page`) || `force_seen`.
  - `force_seen` is set by `force_reload` and cleared when a load starts.
- IDLE → LOAD on a vblank edge with `pending`=1.
  - Latch `target` = `select_text`.
  - Clear `loaded_ok` and `force_seen`.
  - `idx` = 0.
- LOAD:
  - Each cycle, drive `rom_addr` = {target, idx} and increment `idx`, for `N_CHARS` cycles.
  - A 1-cycle delayed copy of `idx` plus a valid bit drives `cram_addr`.
  - `cram_wdata` = `rom_data`; `cram_we` = delayed valid.
  - After the last write: go to IDLE, `loaded_page` <= `target`, `loaded_ok` <= 1, pulse `load_done`.
- Abort: if `vblnk`=0 at any edge while in LOAD:
  - Go to IDLE immediately.
  - `cram_we` is 0 from that edge on; the in-flight ROM read is discarded.
  - `loaded_ok` stays 0, so the next vblank edge performs a full reload from idx 0.
- `select_text` changing during LOAD has no effect on the current load, which completes with the latched `target`. `page_valid` then evaluates 0 and the next vblank edge reloads.
- `force_reload` while busy sets `force_seen`, which causes one additional reload on the next vblank edge.
- `page_valid` is registered: `page_valid` <= `loaded_ok` && (`select_text` == `loaded_page`) && !`busy_next`.
- `rom_addr` high bits always equal `target`. `idx` counts 0..N_CHARS-1 with no wrap beyond.

## Timing
- Reset values: state IDLE, `busy` 0, `load_done` 0, `cram_we` 0, `cram_addr` 0, `cram_wdata` 0, `rom_addr` 0, `loaded_page` 0, `page_valid` 0, `loaded_ok` 0, `force_seen` 0, `vblnk_q` 0.
- Rst asserted mid-load: all of the above apply from the next edge; no further writes.
- For a load started by the vblank edge at cycle E:
  - `busy`=1 from E+1.
  - `rom_addr` carries idx 0..N-1 on cycles E+1..E+N.
  - `cram_we`=1 on cycles E+2..E+N+1, writing idx 0..N-1.
  - `load_done`=1 and `busy`=0 on cycle E+N+2; `page_valid`=1 from E+N+3.
- A change of `select_text` drops `page_valid` on the following cycle.
- Back-to-back loads need a new vblank edge; there is at most one load per vblank.

## Test plan
- **Reset load:** after reset, `select_text`=0, vblnk rises at E.
  - 256 writes on E+2..E+257, `cram_addr` 0..255 with data = ROM[{0,idx}].
  - `load_done` at E+258; `page_valid`=1 at E+259; `loaded_page`=0.
- **Idle frame:** second vblank with no change → `cram_we` never asserted; `busy` stays 0.
- **Page switch:** `select_text` 0→2 mid-frame.
  - `page_valid` 0 one cycle later.
  - Next vblank loads ROM addresses 512..767; then `loaded_page`=2 and `page_valid`=1.
- **Abort:** vblnk falls after 100 writes.
  - `cram_we` 0 from that edge; `busy` 0; no `load_done`; `page_valid` 0.
  - Next vblank rewrites all 256 entries starting at idx 0.
- **Select change mid-load:** `select_text` 1→3 during load.
  - Load finishes with page 1; `loaded_page`=1; `page_valid` 0.
  - Next vblank loads page 3.
- **Reset mid-load:** rst at write 50 → all outputs at reset values next cycle, no writes; the next vblank after release performs a full load.
